// File: rtl/puzzle_regfile.sv
// Register file of 4-bit tile lanes with per-lane masked writes and a
// three-state tile-swap engine that exchanges two lanes of one register.
module puzzle_regfile #(
  parameter int unsigned        DEPTH = 16,
  parameter int unsigned        TILES = 10,
  parameter logic [4*TILES-1:0] INIT0 = 40'h5123450786,
  parameter logic [4*TILES-1:0] INIT1 = 40'h8123456780
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         src0,
  input  logic [3:0]         src1,
  output logic [4*TILES-1:0] data0,
  output logic [4*TILES-1:0] data1,
  input  logic [3:0]         dst,
  input  logic               we,
  input  logic [TILES-1:0]   wmask,
  input  logic [4*TILES-1:0] data,
  input  logic               swp_req,
  input  logic [3:0]         swp_reg,
  input  logic [3:0]         swp_a,
  input  logic [3:0]         swp_b,
  output logic               swp_busy,
  output logic               swp_done,
  output logic               swp_err
);

  localparam int unsigned WIDTH = 4 * TILES;

  typedef enum logic [1:0] {IDLE, CHK, SWAP} state_t;

  state_t             state;
  logic [3:0]         sreg;
  logic [3:0]         sa;
  logic [3:0]         sb;
  logic [WIDTH-1:0]   regs [DEPTH];
  logic [WIDTH-1:0]   nxt  [DEPTH];
  logic [WIDTH-1:0]   swap_word;
  logic [3:0]         lane_a;
  logic [3:0]         lane_b;

  // Read ports: out-of-range addresses read as zero.
  always_comb begin
    data0 = '0;
    data1 = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (32'(src0) == r) data0 = regs[r];
      if (32'(src1) == r) data1 = regs[r];
    end
  end

  // Pre-edge lane values of the swap target, taken from live contents.
  always_comb begin
    swap_word = '0;
    lane_a    = '0;
    lane_b    = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (32'(sreg) == r) swap_word = regs[r];
    end
    for (int unsigned t = 0; t < TILES; t++) begin
      if (32'(sa) == t) lane_a = swap_word[4*t +: 4];
      if (32'(sb) == t) lane_b = swap_word[4*t +: 4];
    end
  end

  // Masked external write first, then the swap overrides its two lanes.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      nxt[r] = regs[r];
      if (we && 32'(dst) == r) begin
        for (int unsigned t = 0; t < TILES; t++) begin
          if (wmask[t]) nxt[r][4*t +: 4] = data[4*t +: 4];
        end
      end
      if (state == SWAP && 32'(sreg) == r) begin
        for (int unsigned t = 0; t < TILES; t++) begin
          if (32'(sa) == t) nxt[r][4*t +: 4] = lane_b;
          if (32'(sb) == t) nxt[r][4*t +: 4] = lane_a;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (r == 0)      regs[r] <= INIT0;
        else if (r == 1) regs[r] <= INIT1;
        else             regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= nxt[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      sa       <= '0;
      sb       <= '0;
      swp_busy <= 1'b0;
      swp_done <= 1'b0;
      swp_err  <= 1'b0;
    end else begin
      swp_done <= 1'b0;
      swp_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (swp_req) begin
            sreg     <= swp_reg;
            sa       <= swp_a;
            sb       <= swp_b;
            state    <= CHK;
            swp_busy <= 1'b1;
          end
        end
        CHK: begin
          if (32'(sreg) < DEPTH && 32'(sa) < TILES && 32'(sb) < TILES) begin
            state <= SWAP;
          end else begin
            state    <= IDLE;
            swp_busy <= 1'b0;
            swp_err  <= 1'b1;
          end
        end
        SWAP: begin
          state    <= IDLE;
          swp_busy <= 1'b0;
          swp_done <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          swp_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
